filtrodown_seq: RTL and testbench
=================================

Name: filtrodown_seq

Overview:
- Sequencer for the 7-tap decimating filter `filtrodown`.
- Accepts one image line as a stream of signed samples and builds each 7-sample window, with edge replication at both ends.
- Fires the filter once per window, captures the filter result after a fixed latency and emits one output per two input samples (2:1 decimation).
- Sits between the line/pixel source and the downstream interpolator stage; it owns all `filtrodown` enable timing.

Parameters:
- DATA_WIDTH, 8, base sample width; all samples and taps are DATA_WIDTH+2 bits signed.
- LINE_LEN, 16, samples per line; must be even and >= 8.
- FILT_LAT, 1, cycles from the filt_enable cycle to a valid filt_out (1..7).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle pulse that begins a line; ignored while busy=1.
- in_valid  in  1  input sample valid.
- in_data  in  DATA_WIDTH+2  signed input sample.
- in_ready  out  1  sequencer accepts in_data this cycle.
- tap0..tap6  out  DATA_WIDTH+2 each  window to filtrodown in0..in6; tap0 is the oldest sample.
- filt_enable  out  1  filter enable, one-cycle pulse per window.
- filt_out  in  DATA_WIDTH+2  filtrodown result.
- out_valid  out  1  out_data valid.
- out_data  out  DATA_WIDTH+2  captured filter result.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  line in progress.
- line_done  out  1  one-cycle pulse after the last output of a line is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; all counters, taps and out_data = 0.
  - in_ready, filt_enable, out_valid, busy and line_done = 0.
  - Reset mid-line aborts the line; no partial outputs survive.
- Function: input x[0..N-1] with N=LINE_LEN gives output y[k], k=0..N/2-1.
  - Window for y[k] is tap0..tap6 = x[2k-3..2k+3].
  - Edge replication: x[i<0] = x[0]; x[i>N-1] = x[N-1].
- Input handshake: a transfer occurs when in_valid & in_ready.
  - in_ready is combinational and equals 1 only in PRIME, FILL, and ADV with in_cnt < N.
- Window shift: win <= {win[1..6], new}; new is in_data, or win[6] when replicating.
- States:
  - IDLE: busy=0. start -> PRIME; in_cnt=0, out_cnt=0.
  - PRIME: on transfer, load all 7 window registers with x0; in_cnt=1; -> FILL.
  - FILL: shift on each transfer; after 3 transfers (window = x[-3..3]) -> FIRE.
  - FIRE: filt_enable=1 for exactly one cycle; -> WAIT.
  - WAIT: count FILT_LAT cycles; on the final cycle register out_data <= filt_out; -> OUT.
  - OUT: out_valid=1; out_data held stable until out_ready.
    - On out_ready: out_cnt++.
    - If out_cnt was N/2-1 -> IDLE and pulse line_done.
    - Otherwise -> ADV with shift count 0.
  - ADV: perform 2 shifts, then -> FIRE.
    - If in_cnt < N, each shift waits for a transfer (in_valid low stalls the FSM).
    - Once in_cnt = N, each shift replicates win[6], takes one cycle and needs no handshake.
- Taps are driven directly from win and stay stable from FIRE through the WAIT capture.
- Throughput without stalls: one output per 2 + 1 + FILT_LAT + 1 cycles.
- First output appears 4 input transfers + 1 + FILT_LAT cycles after start.
- Counter widths: in_cnt is $clog2(LINE_LEN+1) bits; out_cnt is $clog2(LINE_LEN/2) bits.
  - The counters never wrap within a line and clear at start.
- Simultaneous events:
  - start in the same cycle as line_done is ignored; the next line needs start in IDLE.
  - in_valid asserted outside an accepting state is not consumed.
- The sequencer does no arithmetic; widths pass through unchanged.

Decomposition:
- Package filtro_pkg holds:
  - the state encoding (IDLE, PRIME, FILL, FIRE, WAIT, OUT, ADV);
  - NTAPS=7, CENTER=3, DECIM=2;
  - the width function W(DATA_WIDTH)=DATA_WIDTH+2.
- Sub-module filtro_janela: 7-entry signed shift register with load-all, shift-in and replicate controls. It drives tap0..tap6.
- The FSM and the counters stay in filtrodown_seq.

Test Plan:
- Setup for all scenarios: LINE_LEN=8, FILT_LAT=1, bench stub filter registered with 1-cycle latency.
- Centre check: stub out=in3; input 10,20,...,80 with in_valid always high, out_ready high -> outputs 10,30,50,70; line_done pulses once; busy falls the next cycle.
- Left edge: stub out=in0; same input -> outputs 10,10,20,40.
- Right edge: stub out=in6; same input -> outputs 40,60,80,80; in_ready stays 0 during the final ADV replication.
- Backpressure and starvation:
  - out_ready low for 5 cycles on y1 -> out_valid held, out_data=30 stable, in_ready=0, no filt_enable.
  - in_valid low for 3 cycles in ADV -> FSM stalls; outputs are unchanged from the centre check.
- Control: start pulsed mid-line is ignored; reset driven low during WAIT -> all outputs 0 immediately. After release, a fresh line reproduces 10,30,50,70.

Source files
------------

// File: rtl/filtro_pkg.sv
// Shared definitions for the filtrodown sequencer: FSM states, window geometry
// and the sample width derived from the base data width.
package filtro_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_FILL,
        S_FIRE,
        S_WAIT,
        S_OUT,
        S_ADV
    } state_t;

    localparam int NTAPS  = 7;
    localparam int CENTER = 3;
    localparam int DECIM  = 2;

    function automatic int W(input int dw);
        return dw + 2;
    endfunction

endpackage

// File: rtl/filtro_janela.sv
// Seven-entry sample window; entry 0 is the oldest sample, entry NTAPS-1 the newest.
module filtro_janela
    import filtro_pkg::*;
#(
    parameter int SW = 10
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        load,
    input  logic                        shift,
    input  logic                        repl,
    input  logic [SW-1:0]               din,
    output logic [NTAPS-1:0][SW-1:0]    win
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win <= '0;
        end else if (load) begin
            win <= {NTAPS{din}};
        end else if (shift) begin
            for (int i = 0; i < NTAPS - 1; i++) win[i] <= win[i+1];
            // Replication re-enters the newest sample to pad past the line end.
            win[NTAPS-1] <= repl ? win[NTAPS-1] : din;
        end
    end

endmodule

// File: rtl/filtrodown_seq.sv
// Line sequencer for the 7-tap decimating filter: builds edge-replicated windows,
// fires the filter once per window and hands out one result per two input samples.
module filtrodown_seq
    import filtro_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_LEN   = 16,
    parameter int FILT_LAT   = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              in_valid,
    input  logic signed [W(DATA_WIDTH)-1:0]   in_data,
    output logic                              in_ready,
    output logic signed [W(DATA_WIDTH)-1:0]   tap0,
    output logic signed [W(DATA_WIDTH)-1:0]   tap1,
    output logic signed [W(DATA_WIDTH)-1:0]   tap2,
    output logic signed [W(DATA_WIDTH)-1:0]   tap3,
    output logic signed [W(DATA_WIDTH)-1:0]   tap4,
    output logic signed [W(DATA_WIDTH)-1:0]   tap5,
    output logic signed [W(DATA_WIDTH)-1:0]   tap6,
    output logic                              filt_enable,
    input  logic signed [W(DATA_WIDTH)-1:0]   filt_out,
    output logic                              out_valid,
    output logic signed [W(DATA_WIDTH)-1:0]   out_data,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              line_done
);

    localparam int SW  = W(DATA_WIDTH);
    localparam int ICW = $clog2(LINE_LEN + 1);
    localparam int OCW = $clog2(LINE_LEN / DECIM);
    localparam int WCW = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;

    localparam logic [ICW-1:0] IN_LAST  = ICW'(LINE_LEN);
    localparam logic [OCW-1:0] OUT_LAST = OCW'(LINE_LEN / DECIM - 1);
    localparam logic [WCW-1:0] W_LAST   = WCW'(FILT_LAT - 1);

    state_t               state;
    logic [ICW-1:0]       in_cnt;
    logic [OCW-1:0]       out_cnt;
    logic [1:0]           sh_cnt;
    logic [WCW-1:0]       w_cnt;
    logic [NTAPS-1:0][SW-1:0] win;

    logic xfer, repl_step, win_load, win_shift;

    assign in_ready  = (state == S_PRIME) || (state == S_FILL) ||
                       ((state == S_ADV) && (in_cnt < IN_LAST));
    assign xfer      = in_valid && in_ready;
    assign repl_step = (state == S_ADV) && (in_cnt >= IN_LAST);
    assign win_load  = (state == S_PRIME) && xfer;
    assign win_shift = ((state == S_FILL) && xfer) ||
                       ((state == S_ADV) && (xfer || repl_step));

    filtro_janela #(.SW(SW)) u_janela (
        .clock (clock),
        .reset (reset),
        .load  (win_load),
        .shift (win_shift),
        .repl  (repl_step),
        .din   (in_data),
        .win   (win)
    );

    assign tap0 = win[0];
    assign tap1 = win[1];
    assign tap2 = win[2];
    assign tap3 = win[3];
    assign tap4 = win[4];
    assign tap5 = win[5];
    assign tap6 = win[6];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            in_cnt      <= '0;
            out_cnt     <= '0;
            sh_cnt      <= '0;
            w_cnt       <= '0;
            out_data    <= '0;
            filt_enable <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            line_done   <= 1'b0;
        end else begin
            filt_enable <= 1'b0;
            line_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A start coinciding with the done pulse belongs to the old line.
                    if (start && !line_done) begin
                        state   <= S_PRIME;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_PRIME: begin
                    if (xfer) begin
                        in_cnt <= ICW'(1);
                        sh_cnt <= '0;
                        state  <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (xfer) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (sh_cnt == 2'd2) begin
                            sh_cnt      <= '0;
                            filt_enable <= 1'b1;
                            state       <= S_FIRE;
                        end else begin
                            sh_cnt <= sh_cnt + 1'b1;
                        end
                    end
                end
                S_FIRE: begin
                    w_cnt <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_cnt == W_LAST) begin
                        out_data  <= filt_out;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        w_cnt <= w_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_cnt == OUT_LAST) begin
                            busy      <= 1'b0;
                            line_done <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                            sh_cnt  <= '0;
                            state   <= S_ADV;
                        end
                    end
                end
                S_ADV: begin
                    if (xfer || repl_step) begin
                        if (xfer) in_cnt <= in_cnt + 1'b1;
                        if (sh_cnt == 2'd1) begin
                            sh_cnt      <= '0;
                            filt_enable <= 1'b1;
                            state       <= S_FIRE;
                        end else begin
                            sh_cnt <= sh_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filtrodown_seq.sv
// Bench for filtrodown_seq with a registered stub filter that forwards one chosen tap.
module tb_filtrodown_seq;
    localparam int DW = 8;
    localparam int N  = 8;
    localparam int SW = DW + 2;
    localparam int NO = N / 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic signed [SW-1:0] in_data = '0;
    logic signed [SW-1:0] filt_out;
    logic signed [SW-1:0] tap0, tap1, tap2, tap3, tap4, tap5, tap6, out_data;
    logic in_ready, filt_enable, out_valid, busy, line_done;

    int sel = 3;
    int checks = 0;
    int failures = 0;
    logic signed [SW-1:0] line_x [N];
    int in_idx;
    logic signed [SW-1:0] got [$];

    typedef struct {
        int sel;
        int hold_k;
        int stall_k;
        int restart;
        logic signed [SW-1:0] y [NO];
    } vec_t;
    vec_t tbl [6];

    always #5 clock = ~clock;

    filtrodown_seq #(.DATA_WIDTH(DW), .LINE_LEN(N), .FILT_LAT(1)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3),
        .tap4(tap4), .tap5(tap5), .tap6(tap6),
        .filt_enable(filt_enable), .filt_out(filt_out),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .line_done(line_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) filt_out <= '0;
        else if (filt_enable) begin
            case (sel)
                0: filt_out <= tap0;
                1: filt_out <= tap1;
                2: filt_out <= tap2;
                3: filt_out <= tap3;
                4: filt_out <= tap4;
                5: filt_out <= tap5;
                default: filt_out <= tap6;
            endcase
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Output k sees samples x[2k-3 .. 2k+3] with clamping; the stub picks one of them.
    function automatic logic signed [SW-1:0] ref_y(input int k);
        int i;
        i = 2 * k - 3 + sel;
        if (i < 0) i = 0;
        if (i > N - 1) i = N - 1;
        return line_x[i];
    endfunction

    function automatic logic signed [SW-1:0] src_data(input int idx);
        if (idx < N) return line_x[idx];
        return 10'sh155;
    endfunction

    task automatic run_line(input string tag, input int p_inv, input int p_nrdy,
                            input int hold_k, input int stall_k, input int mid_st,
                            input int restart, input logic signed [SW-1:0] exp [NO]);
        int cyc, nxfer, nfire, ndone, viol, hold_cnt, stall_cnt, idle_bad, busy_at_done;
        logic xfer, acc, prev_stall;
        logic signed [SW-1:0] prev_data;
        got.delete();
        in_idx = 0; nxfer = 0; nfire = 0; ndone = 0; viol = 0; hold_cnt = 0;
        stall_cnt = 0; idle_bad = 0; busy_at_done = 1; prev_stall = 1'b0; prev_data = '0;
        cyc = 0;
        start = 1'b1;
        in_valid = ($urandom_range(0, 99) >= p_inv);
        in_data = src_data(0);
        out_ready = 1'b1;
        while (!(ndone > 0 && got.size() == NO) && cyc < 400) begin
            @(negedge clock);
            xfer = in_valid && in_ready;
            if (filt_enable) nfire++;
            if (line_done) begin ndone++; busy_at_done = busy; end
            if (out_valid && (in_ready || filt_enable)) viol++;
            if (prev_stall && (!out_valid || out_data !== prev_data)) viol++;
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && !out_ready && got.size() == hold_k) hold_cnt++;
            acc = out_valid && out_ready;
            if (acc) got.push_back(out_data);
            if (ndone > 0 && got.size() == NO) break;
            @(posedge clock); #1;
            start = 1'b0;
            if (xfer) begin in_idx++; nxfer++; end
            if (acc && (got.size() - 1) == stall_k) stall_cnt = 3;
            if (stall_cnt > 0) begin
                in_valid = 1'b0;
                stall_cnt--;
            end else begin
                in_valid = ($urandom_range(0, 99) >= p_inv);
            end
            in_data = src_data(in_idx);
            if (out_valid && got.size() == hold_k && hold_cnt < 5) out_ready = 1'b0;
            else out_ready = ($urandom_range(0, 99) >= p_nrdy);
            if (mid_st != 0 && cyc == 10) start = 1'b1;
            if (restart != 0 && line_done) start = 1'b1;
            cyc++;
        end
        chk({tag, ".timeout"}, (cyc < 400) ? 1 : 0, 1);
        chk({tag, ".nout"}, got.size(), NO);
        for (int k = 0; k < NO && k < got.size(); k++)
            chk($sformatf("%s.y%0d", tag, k), got[k], exp[k]);
        chk({tag, ".nxfer"}, nxfer, N);
        chk({tag, ".nfire"}, nfire, NO);
        chk({tag, ".ndone"}, ndone, 1);
        chk({tag, ".busy_at_done"}, busy_at_done, 0);
        chk({tag, ".hold_viol"}, viol, 0);
        if (hold_k >= 0) chk({tag, ".hold_cycles"}, hold_cnt, 5);
        @(posedge clock); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 10'sh155;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (busy || in_ready || line_done || out_valid) idle_bad++;
        end
        in_valid = 1'b0;
        chk({tag, ".idle_after"}, idle_bad, 0);
        @(posedge clock); #1;
    endtask

    initial begin
        logic signed [SW-1:0] exp [NO];
        int found;

        #1;
        chk("rst.busy", busy, 0);
        chk("rst.in_ready", in_ready, 0);
        chk("rst.filt_enable", filt_enable, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.line_done", line_done, 0);
        chk("rst.out_data", out_data, 0);
        chk("rst.tap0", tap0, 0);
        chk("rst.tap6", tap6, 0);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;

        tbl[0] = '{3, -1, -1, 1, '{10'sd10, 10'sd30, 10'sd50, 10'sd70}};
        tbl[1] = '{0, -1, -1, 0, '{10'sd10, 10'sd10, 10'sd20, 10'sd40}};
        tbl[2] = '{6, -1, -1, 0, '{10'sd40, 10'sd60, 10'sd80, 10'sd80}};
        tbl[3] = '{5, -1, -1, 0, '{10'sd30, 10'sd50, 10'sd70, 10'sd80}};
        tbl[4] = '{3,  1, -1, 0, '{10'sd10, 10'sd30, 10'sd50, 10'sd70}};
        tbl[5] = '{3, -1,  0, 0, '{10'sd10, 10'sd30, 10'sd50, 10'sd70}};

        for (int i = 0; i < N; i++) line_x[i] = SW'(10 * (i + 1));
        for (int t = 0; t < 6; t++) begin
            sel = tbl[t].sel;
            run_line($sformatf("tbl%0d", t), 0, 0, tbl[t].hold_k, tbl[t].stall_k,
                     (t == 1) ? 1 : 0, tbl[t].restart, tbl[t].y);
        end

        // Reset while the filter result is pending, then a clean line afterwards.
        sel = 3; in_idx = 0;
        start = 1'b1; in_valid = 1'b1; in_data = src_data(0); out_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 50 && found == 0; c++) begin
            @(negedge clock);
            if (filt_enable) found = 1;
            else begin
                if (in_valid && in_ready) begin
                    @(posedge clock); #1; in_idx++;
                end else begin
                    @(posedge clock); #1;
                end
                start = 1'b0;
                in_data = src_data(in_idx);
            end
        end
        chk("wait_rst.reached_fire", found, 1);
        @(posedge clock); #1;
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("wait_rst.busy", busy, 0);
        chk("wait_rst.in_ready", in_ready, 0);
        chk("wait_rst.filt_enable", filt_enable, 0);
        chk("wait_rst.out_valid", out_valid, 0);
        chk("wait_rst.out_data", out_data, 0);
        chk("wait_rst.tap3", tap3, 0);
        chk("wait_rst.tap6", tap6, 0);
        @(negedge clock); @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        run_line("after_rst", 0, 0, -1, -1, 0, 0, tbl[0].y);

        // Random lines, random tap choice and random handshakes against the window model.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) line_x[i] = SW'($urandom_range(0, 1023));
            sel = $urandom_range(0, 6);
            for (int k = 0; k < NO; k++) exp[k] = ref_y(k);
            run_line($sformatf("rnd%0d", r), 30, 30, -1, -1, r % 2, 0, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
